// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : div_pkg
// Purpose  : Shared FSM states and sizing constants for the sequential divider.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int WIDTH      = 8;
  localparam int ITERATIONS = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trial_subtractor8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : trial_subtractor8
// Purpose  : 9-bit partial remainder minus 8-bit divisor; bit 8 is the borrow.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module trial_subtractor8 (
  input  logic [8:0] partial,
  input  logic [7:0] divisor,
  output logic [7:0] diff,
  output logic       borrow
);

  logic [8:0] w_full;

  assign w_full = partial - {1'b0, divisor};
  assign diff   = w_full[7:0];
  assign borrow = w_full[8];

endmodule
`default_nettype wire

// File: rtl/seq_divider8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_divider8
// Purpose  : 8-bit restoring divider, one quotient bit per cycle, MSB first.
//            Optional macro SEQ_DIVIDER8_SIGNED_EN adds two's-complement mode.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_divider8 #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef SEQ_DIVIDER8_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import div_pkg::*;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_by_zero;

  logic               w_zero;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH-1:0]   w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;
  logic               w_last;

`ifdef SEQ_DIVIDER8_SIGNED_EN
  assign w_dvd_neg = signed_op & dividend[WIDTH-1];
  assign w_dvs_neg = signed_op & divisor[WIDTH-1];
`else
  assign w_dvd_neg = 1'b0;
  assign w_dvs_neg = 1'b0;
`endif

  assign w_zero    = (divisor == '0);
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

  // Dividend register shifts out its MSB each step and collects quotient bits at the LSB.
  assign w_partial = {r_rem, r_dvd[WIDTH-1]};

  trial_subtractor8 u_trial (
    .partial (w_partial),
    .divisor (r_dvs),
    .diff    (w_diff),
    .borrow  (w_borrow)
  );

  assign w_rem_next = w_borrow ? w_partial[WIDTH-1:0] : w_diff;
  assign w_quo_next = {r_dvd[WIDTH-2:0], ~w_borrow};
  assign w_last     = (r_count == CNT_W'(ITERATIONS - 1));

  // Sign restoration happens on the way into the output registers, so DONE costs no extra cycle.
  assign w_q_final  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final  = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_zero ? DONE : RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count       <= '0;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_count <= '0;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            if (w_zero) begin
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem_next;
          r_dvd   <= w_quo_next;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_quotient    <= w_q_final;
            r_remainder   <= w_r_final;
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_seq_divider8
// Purpose  : Self-checking bench for seq_divider8 (directed table, corner
//            sequences, randomized operands against an arithmetic model).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_seq_divider8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       signed_op = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_accept = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef SEQ_DIVIDER8_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; SV int division truncates toward zero.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    sa = (s && a[7]) ? int'(a) - 256 : int'(a);
    sb = (s && b[7]) ? int'(b) - 256 : int'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, q[7:0], r[7:0]};
  endfunction

  // lat = edges after the accepting edge until done is seen (#1 after that edge).
  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    last_accept = cyc;
    check({name, " busy after accept"}, busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, (b == 8'd0) ? 0 : 8);
    check({name, " done"}, done, 1);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_by_zero"}, div_by_zero, ez);
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, done, 0);
    check({name, " idle after done"}, busy, 0);
    check({name, " quotient held"}, quotient, eq);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_accept;
    int cnt;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    logic [16:0] m;

    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[3] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tbl[5] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
    tbl[6] = '{8'd128, 8'd2,   8'd64,  8'd0,  1'b0};
    tbl[7] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back: each request is issued in the idle cycle right after done.
    prev_accept = 0;
    for (int i = 0; i < 8; i++) begin
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].q, tbl[i].r, tbl[i].z);
      if (i > 0) check($sformatf("vec%0d accept spacing", i), last_accept - prev_accept,
                       (tbl[i-1].b == 8'd0) ? 2 : 10);
      prev_accept = last_accept;
    end

    // Reset in the middle of RUN, with the 37/0 results still on the outputs.
    @(negedge clk);
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun busy", busy, 1);
    check("midrun results hidden", quotient, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset quotient", quotient, 0);
    check("async reset remainder", remainder, 0);
    check("async reset div_by_zero", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    check("no activity after reset release", cnt, 0);

    // Second start while busy must be dropped and must not disturb operands.
    @(negedge clk);
    dividend = 8'd100;
    divisor = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 8'd10;
    divisor = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'd77;
    divisor = 8'd0;
    cnt = 4;
    while (!done && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("ignored start latency", cnt, 8);
    check("ignored start quotient", quotient, 8'd10);
    check("ignored start remainder", remainder, 8'd0);
    check("ignored start div_by_zero", div_by_zero, 0);
    cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("dropped request produced no done", cnt, 0);

`ifdef SEQ_DIVIDER8_SIGNED_EN
    run_div("s -100/7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0);
    run_div("s -128/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
    run_div("s 100/-7", 8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0);
    run_div("s -5/0", 8'hFB, 8'h00, 1'b1, 8'hFF, 8'hFB, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
`ifdef SEQ_DIVIDER8_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rs);
      run_div($sformatf("rand%0d %0d/%0d s%0d", i, ra, rb, rs), ra, rb, rs, m[15:8], m[7:0], m[16]);
    end

    check("final signed_op idle level", signed_op, rs);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
